// File: rtl/wb_fpga_aperture_decoder_if.sv
// Bridge-side Wishbone bus between the AHB-to-FPGA bridge and the aperture decoder.
interface wb_fpga_aperture_decoder_if #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32
);
  logic [ADDRWIDTH-1:0] adr;
  logic                 cyc;
  logic                 stb;
  logic [DATAWIDTH-1:0] dat;
  logic                 ack;

  modport master (output adr, output cyc, output stb, input dat, input ack);
  modport slave  (input adr, input cyc, input stb, output dat, output ack);
endinterface

// File: rtl/wb_fpga_aperture_decoder.sv
// Aperture decoder: routes one bridge cycle to slave 0, slave 1 or the QL
// reserved/default block, returns a registered response and counts stray acks.
//
// state | meaning
// IDLE  | no transfer; decode captured on cyc&stb
// BUSY  | selected slave sees cyc, waiting for its ack or an abort
// RESP  | one-cycle ack to the bridge with captured read data
module wb_fpga_aperture_decoder #(
  parameter int                   ADDRWIDTH = 17,
  parameter int                   DATAWIDTH = 32,
  parameter int                   REG_MSB   = 16,
  parameter int                   REG_LSB   = 9,
  parameter logic [ADDRWIDTH-1:0] SLV0_BASE = 17'h0,
  parameter logic [ADDRWIDTH-1:0] SLV1_BASE = 17'h200,
  parameter logic [ADDRWIDTH-1:0] RSVD_BASE = 17'h1E00
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  wb_fpga_aperture_decoder_if.slave wbs,
  output logic                 WBs_CYC_S0_o,
  output logic                 WBs_CYC_S1_o,
  output logic                 WBs_CYC_QL_Reserved_o,
  input  logic [DATAWIDTH-1:0] WBs_DAT_S0_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_S1_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_RSVD_i,
  input  logic                 WBs_ACK_S0_i,
  input  logic                 WBs_ACK_S1_i,
  input  logic                 WBs_ACK_RSVD_i,
  output logic                 WBs_ACK_Any_o,
  input  logic                 Err_Clr_i,
  output logic [7:0]           Err_Cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {SEL_DEF, SEL_S0, SEL_S1, SEL_RSVD} sel_t;

  state_t state, next_state;
  sel_t   sel, next_sel, dec_sel;
  logic   dat_load;
  logic   stray_ack;
  logic   sel_ack;
  logic   busy_stray;
  logic [DATAWIDTH-1:0] sel_dat;
  logic [DATAWIDTH-1:0] dat_q;

  logic unused_adr_bits;
  assign unused_adr_bits = ^wbs.adr[REG_LSB-1:0];

  assign WBs_ACK_Any_o = WBs_ACK_S0_i | WBs_ACK_S1_i | WBs_ACK_RSVD_i;
  assign wbs.ack       = (state == RESP);
  assign wbs.dat       = dat_q;

  // Region decode with S0 > S1 > RSVD priority when bases overlap.
  always_comb begin
    dec_sel = SEL_DEF;
    if (wbs.adr[REG_MSB:REG_LSB] == SLV0_BASE[REG_MSB:REG_LSB])
      dec_sel = SEL_S0;
    else if (wbs.adr[REG_MSB:REG_LSB] == SLV1_BASE[REG_MSB:REG_LSB])
      dec_sel = SEL_S1;
    else if (wbs.adr[REG_MSB:REG_LSB] == RSVD_BASE[REG_MSB:REG_LSB])
      dec_sel = SEL_RSVD;
  end

  // Selected-slave ack/data and the acks that are stray for the current select.
  always_comb begin
    sel_ack    = WBs_ACK_RSVD_i;
    sel_dat    = WBs_DAT_RSVD_i;
    busy_stray = WBs_ACK_S0_i | WBs_ACK_S1_i;
    case (sel)
      SEL_S0: begin
        sel_ack    = WBs_ACK_S0_i;
        sel_dat    = WBs_DAT_S0_i;
        busy_stray = WBs_ACK_S1_i | WBs_ACK_RSVD_i;
      end
      SEL_S1: begin
        sel_ack    = WBs_ACK_S1_i;
        sel_dat    = WBs_DAT_S1_i;
        busy_stray = WBs_ACK_S0_i | WBs_ACK_RSVD_i;
      end
      default: ;
    endcase
  end

  // Next-state, cycle selects and error-increment decision.
  always_comb begin
    next_state            = state;
    next_sel              = sel;
    dat_load              = 1'b0;
    stray_ack             = 1'b0;
    WBs_CYC_S0_o          = 1'b0;
    WBs_CYC_S1_o          = 1'b0;
    WBs_CYC_QL_Reserved_o = 1'b0;
    case (state)
      IDLE: begin
        stray_ack = WBs_ACK_Any_o;
        if (wbs.cyc && wbs.stb) begin
          next_state = BUSY;
          next_sel   = dec_sel;
        end
      end
      BUSY: begin
        stray_ack             = busy_stray;
        WBs_CYC_S0_o          = (sel == SEL_S0)   && wbs.cyc;
        WBs_CYC_S1_o          = (sel == SEL_S1)   && wbs.cyc;
        WBs_CYC_QL_Reserved_o = (sel == SEL_RSVD) && wbs.cyc;
        if (sel_ack) begin
          dat_load   = 1'b1;
          next_state = RESP;
        end else if (!wbs.cyc) begin
          next_state = IDLE;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, select, read-data capture and saturating stray-ack counter.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state     <= IDLE;
      sel       <= SEL_DEF;
      dat_q     <= '0;
      Err_Cnt_o <= 8'h00;
    end else begin
      state <= next_state;
      sel   <= next_sel;
      if (dat_load)
        dat_q <= sel_dat;
      if (Err_Clr_i)
        Err_Cnt_o <= 8'h00;
      else if (stray_ack && (Err_Cnt_o != 8'hFF))
        Err_Cnt_o <= Err_Cnt_o + 8'h01;
    end
  end

endmodule
